// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: one digit per clock, MS digit first,
// with valid/ready handshakes on both sides.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err,
  output logic                busy
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SrW  = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             state_q, state_d;
  logic [SrW-1:0]     sr_q, sr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic [3:0]         digit;
  logic [BIN_W-1:0]   acc_next;
  logic               digit_bad;

  assign digit     = sr_q[SrW-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  // acc*10 + digit as two shifts and adds; raw nibbles 10..15 are added unchanged.
  assign acc_next  = {acc_q[BIN_W-4:0], 3'b000} + {acc_q[BIN_W-2:0], 1'b0} + BIN_W'(digit);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d    = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = acc_next;
        err_d = err_q | digit_bad;
        sr_d  = {sr_q[SrW-5:0], 4'b0000};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIGITS - 1)) begin
          bin_d   = acc_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign bin_out   = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, random words against an arithmetic
// reference, and hand-written backpressure / mid-conversion reset sequences.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bin_out;
  logic        err;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  bcd_to_bin #(.DIGITS(6), .BIN_W(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bcd;
    logic [19:0] exp_bin;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: positional decimal value of the nibbles, truncated to 20 bits.
  function automatic void model(input logic [23:0] b, output logic [19:0] v, output logic e);
    int unsigned acc;
    int unsigned d;
    acc = 0;
    e   = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      d   = (b >> (4 * i)) & 32'hF;
      acc = acc * 10 + d;
      if (d > 9) e = 1'b1;
    end
    v = 20'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, measure latency, optionally stall, then complete the handshake.
  task automatic convert(input logic [23:0] bcd, input int hold, input string name,
                         input logic [19:0] exp_bin, input logic exp_err);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    bcd_in   = bcd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bcd_in   = $urandom;  // must not disturb the conversion in progress
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd6);
    check({name, " bin"}, 32'(bin_out), 32'(exp_bin));
    check({name, " err"}, 32'(err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, " hold valid"}, 32'(out_valid), 32'd1);
      check({name, " hold bin"}, 32'(bin_out), 32'(exp_bin));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " drop valid"}, 32'(out_valid), 32'd0);
    check({name, " kept bin"}, 32'(bin_out), 32'(exp_bin));
  endtask

  vec_t        vecs[8];
  logic [19:0] m_bin;
  logic        m_err;
  logic [23:0] rb;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;

    vecs[0] = '{24'h123456, 20'h1E240, 1'b0};
    vecs[1] = '{24'h999999, 20'hF423F, 1'b0};
    vecs[2] = '{24'h000000, 20'h00000, 1'b0};
    vecs[3] = '{24'h12A456, 20'd130456, 1'b1};
    vecs[4] = '{24'h900000, 20'd900000, 1'b0};
    vecs[5] = '{24'h000009, 20'd9, 1'b0};
    vecs[6] = '{24'hFFFFFF, 20'd618089, 1'b1};
    vecs[7] = '{24'h00000B, 20'd11, 1'b1};

    tick();
    tick();
    reset = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset bin", 32'(bin_out), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bcd, i % 3, $sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_err);
    end

    // Backpressure: stalled result, competing input must wait.
    bcd_in   = 24'h000042;
    in_valid = 1'b1;
    tick();
    bcd_in = 24'h000007;
    for (int i = 0; i < 6; i++) tick();
    check("bp valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold bin", 32'(bin_out), 32'd42);
      check("bp hold busy", 32'(busy), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp drop valid", 32'(out_valid), 32'd0);
    check("bp idle ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp accepted", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("bp second valid", 32'(out_valid), 32'd1);
    check("bp second bin", 32'(bin_out), 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset on the third conversion edge discards the partial result.
    bcd_in   = 24'h555555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst idle ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst no valid", 32'(out_valid), 32'd0);
    end
    convert(24'h000010, 0, "after rst", 20'd10, 1'b0);

    // Random words, half restricted to legal digits.
    for (int i = 0; i < 40; i++) begin
      rb = 24'($urandom);
      if (i % 2 == 0) begin
        for (int k = 0; k < 6; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      model(rb, m_bin, m_err);
      convert(rb, $urandom_range(0, 2), $sformatf("rand%0d", i), m_bin, m_err);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
